// File: rtl/tdm_demux_pkg.sv
// Shared constants and FSM encoding for the 8-channel TDM receive path.
package tdm_demux_pkg;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;
    localparam logic [SEL_W-1:0] SLOT_LAST = 3'd7;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter: load-to-1 on an accepted sync beat, +1 per data beat.
// wrap_o marks the last slot of the frame.
module tdm_slot_ctr
    import tdm_demux_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load1_i,
    input  logic             inc_i,
    output logic [SEL_W-1:0] sel_o,
    output logic             wrap_o
);

    logic [SEL_W-1:0] sel_q, sel_d;

    always_comb begin
        sel_d = sel_q;
        if (load1_i) begin
            sel_d = SEL_W'(1);
        end else if (inc_i) begin
            sel_d = sel_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

    assign sel_o  = sel_q;
    assign wrap_o = (sel_q == SLOT_LAST);

endmodule

// File: rtl/tdm_demux8_rx.sv
// TDM 8:1 receive demux; q/q_valid appear 1 cycle after the slot-7 beat, no backpressure.
// Optional SYNC_CHECK_EN adds a sticky sync_err flag; recovery is identical either way.
module tdm_demux8_rx
    import tdm_demux_pkg::*;
#(
    parameter int W = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [W-1:0]       din,
    input  logic               din_valid,
    input  logic               frame_start,
    output logic [NCH*W-1:0]   q,
    output logic               q_valid,
    output logic [SEL_W-1:0]   sel,
    output logic               sync_err
);

    rx_state_t        state_q, state_d;
    logic [W-1:0]     shadow_q [0:NCH-2];
    logic [NCH*W-1:0] q_q, q_next;
    logic             q_valid_q;
    logic             load1, inc, wrap, publish;

    tdm_slot_ctr u_slot_ctr (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .load1_i (load1),
        .inc_i   (inc),
        .sel_o   (sel),
        .wrap_o  (wrap)
    );

    // frame_start always restarts the frame, in HUNT or as an early sync in COLLECT.
    always_comb begin
        state_d = state_q;
        load1   = 1'b0;
        inc     = 1'b0;
        publish = 1'b0;
        if (din_valid) begin
            if (frame_start) begin
                load1   = 1'b1;
                state_d = COLLECT;
            end else if (state_q == COLLECT) begin
                if (sel == '0) begin
                    state_d = HUNT;
                end else begin
                    inc     = 1'b1;
                    publish = wrap;
                end
            end
        end
    end

    // The slot-7 sample goes straight into q, so it needs no shadow register.
    always_comb begin
        q_next = '0;
        for (int k = 0; k < NCH - 1; k++) begin
            q_next[k*W +: W] = shadow_q[k];
        end
        q_next[(NCH-1)*W +: W] = din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            for (int k = 0; k < NCH - 1; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            q_valid_q <= publish;
            if (publish) begin
                q_q <= q_next;
            end
            if (load1) begin
                shadow_q[0] <= din;
            end else if (inc && !wrap) begin
                shadow_q[sel] <= din;
            end
        end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;

`ifdef SYNC_CHECK_EN
    logic sync_err_q;
    logic sync_evt;

    assign sync_evt = din_valid && (state_q == COLLECT) &&
                      (frame_start ? (sel != '0) : (sel == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_err_q <= 1'b0;
        end else if (sync_evt) begin
            sync_err_q <= 1'b1;
        end
    end

    assign sync_err = sync_err_q;
`else
    assign sync_err = 1'b0;
`endif

endmodule
